// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data load/store.
// Optional busy timeout with sticky ERR is enabled by defining ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate between eligible requesters
// BUSY_I | fetch presented on MEM_*, waiting for MEM_ACK
// BUSY_D | load/store presented on MEM_*, waiting for MEM_ACK
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [3:0]  D_BE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL_IF,
  output logic        STALL_MEM,
  output logic        ERR
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT must be within 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..255");
  end

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       i_elig, d_elig, grant_i, grant_d, done, abort;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
`endif

  assign STALL_IF  = I_REQ & ~I_ACK;
  assign STALL_MEM = D_REQ & ~D_ACK;

  always_ff @(posedge CLK) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    // an ACK output still high marks the trailing REQ cycle of a finished access
    i_elig    = I_REQ & ~I_ACK;
    d_elig    = D_REQ & ~D_ACK;
    case (state)
      IDLE: begin
        if (d_elig && (!i_elig || starve_cnt != STARVE_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_elig) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (MEM_ACK) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_BE     <= 4'h0;
      MEM_ADDR   <= 32'h0;
      MEM_WDATA  <= 32'h0;
      I_ACK      <= 1'b0;
      D_ACK      <= 1'b0;
      I_RDATA    <= 32'h0;
      D_RDATA    <= 32'h0;
      starve_cnt <= 4'h0;
    end else begin
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      if (grant_d) begin
        MEM_REQ   <= 1'b1;
        MEM_WE    <= D_WE;
        MEM_BE    <= D_BE;
        MEM_ADDR  <= D_ADDR;
        MEM_WDATA <= D_WDATA;
        if (I_REQ && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'h1;
      end else if (grant_i) begin
        MEM_REQ    <= 1'b1;
        MEM_WE     <= 1'b0;
        MEM_BE     <= 4'hF;
        MEM_ADDR   <= I_ADDR;
        MEM_WDATA  <= 32'h0;
        starve_cnt <= 4'h0;
      end
      // an aborted access returns zero data to whichever side owned it
      if (done || abort) begin
        MEM_REQ <= 1'b0;
        if (state == BUSY_I) begin
          I_ACK   <= 1'b1;
          I_RDATA <= done ? MEM_RDATA : 32'h0;
        end else begin
          D_ACK <= 1'b1;
          if (abort)        D_RDATA <= 32'h0;
          else if (!MEM_WE) D_RDATA <= MEM_RDATA;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tmo_cnt <= 8'h0;
      ERR     <= 1'b0;
    end else begin
      if (grant_i || grant_d)                        tmo_cnt <= 8'h0;
      else if (state != IDLE && !MEM_ACK && !abort)  tmo_cnt <= tmo_cnt + 8'h1;
      if (abort) ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized fetch/data traffic against a
// reactive memory model, plus directed latency, reset, contention and timeout cases.
module tb_mem_port_arbiter;
  localparam int LIMIT = 3;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_ACK;
  logic [31:0] I_RDATA;
  logic        D_REQ;
  logic        D_WE;
  logic [3:0]  D_BE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        STALL_IF;
  logic        STALL_MEM;
  logic        ERR;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(15)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .STALL_IF(STALL_IF), .STALL_MEM(STALL_MEM), .ERR(ERR)
  );

  initial forever #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int issued = 0;
  int hshk = 0;
  bit mem_en = 1'b1;
  int fixed_lat = -1;
  int wait_cnt = 0;
  logic [31:0] d_last = 32'h0;

  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  logic [31:0] i_pay[$];
  logic [68:0] d_pay[$];
  int          grant_q[$];

  function automatic void chk(string nm, logic [68:0] act, logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void miss(string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none pending at %0t", nm, $time);
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int pick_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
  endfunction

  // memory model: acks after wait_cnt extra request cycles, checks the presented payload
  initial begin
    MEM_ACK = 1'b0;
    MEM_RDATA = 32'h0;
    forever begin
      @(negedge CLK);
      if (mem_en) begin
        MEM_ACK = 1'b0;
        if (MEM_REQ === 1'b1) begin
          if (wait_cnt == 0) begin
            MEM_ACK = 1'b1;
            MEM_RDATA = mem_data(MEM_ADDR);
            hshk++;
            if (MEM_ADDR[31]) begin
              grant_q.push_back(1);
              if (d_pay.size() == 0) miss("mem_d_unexpected");
              else chk("mem_d_payload", {MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}, d_pay.pop_front());
            end else begin
              grant_q.push_back(0);
              if (i_pay.size() == 0) miss("mem_i_unexpected");
              else chk("mem_i_payload", {MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA},
                       {1'b0, 4'hF, i_pay.pop_front(), 32'h0});
            end
            wait_cnt = pick_lat();
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // response monitor
  initial forever begin
    @(negedge CLK);
    if (I_ACK === 1'b1) begin
      if (i_exp.size() == 0) miss("spurious_i_ack");
      else chk("i_rdata", I_RDATA, i_exp.pop_front());
    end
    if (D_ACK === 1'b1) begin
      if (d_exp.size() == 0) miss("spurious_d_ack");
      else chk("d_rdata", D_RDATA, d_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_i(input int n, input bit gaps);
    logic [31:0] a;
    int w;
    for (int k = 0; k < n; k++) begin
      a = {1'b0, 29'($urandom), 2'b00};
      i_pay.push_back(a);
      i_exp.push_back(mem_data(a));
      issued++;
      I_ADDR = a;
      I_REQ = 1'b1;
      w = 0;
      do begin @(negedge CLK); w++; end while (I_ACK !== 1'b1 && w < 100);
      if (I_ACK !== 1'b1) miss("i_ack_timeout");
      if (gaps) begin
        I_REQ = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
    end
    I_REQ = 1'b0;
  endtask

  task automatic drive_d(input int n, input bit gaps);
    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  be;
    int w;
    for (int k = 0; k < n; k++) begin
      a  = {1'b1, 29'($urandom), 2'b00};
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      wd = $urandom | 32'h1;
      d_pay.push_back({we, be, a, wd});
      if (!we) d_last = mem_data(a);
      d_exp.push_back(d_last);
      issued++;
      D_WE = we; D_BE = be; D_ADDR = a; D_WDATA = wd;
      D_REQ = 1'b1;
      w = 0;
      do begin @(negedge CLK); w++; end while (D_ACK !== 1'b1 && w < 100);
      if (D_ACK !== 1'b1) miss("d_ack_timeout");
      if (gaps) begin
        D_REQ = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
    end
    D_REQ = 1'b0;
  endtask

  initial begin
    int cyc, w, busy;
    int exp_order[$];
    int i_left, d_left, prev, starve;

    RSTN = 1'b0;
    I_REQ = 1'b0; I_ADDR = 32'h0;
    D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'h0; D_ADDR = 32'h0; D_WDATA = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_acks", {I_ACK, D_ACK, ERR, MEM_WE}, 0);
    chk("rst_mem_fields", {MEM_BE, MEM_ADDR, MEM_WDATA}, 0);
    chk("rst_rdata", {I_RDATA, D_RDATA}, 0);
    RSTN = 1'b1;
    @(negedge CLK);

    // single fetch, memory acks in the first request cycle; REQ trails one cycle past ACK
    fixed_lat = 0; wait_cnt = 0;
    i_pay.push_back(32'h100);
    i_exp.push_back(32'h0050_0093);
    issued++;
    I_ADDR = 32'h100; I_REQ = 1'b1;
    #1 chk("stall_if_t", STALL_IF, 1);
    cyc = 0;
    do begin
      @(negedge CLK); cyc++;
      if (I_ACK !== 1'b1) chk("stall_if_wait", STALL_IF, 1);
    end while (I_ACK !== 1'b1 && cyc < 20);
    chk("fetch_latency", cyc, 2);
    chk("stall_if_ack", STALL_IF, 0);
    @(negedge CLK);
    chk("i_ack_single_pulse", I_ACK, 0);
    chk("trailing_no_memreq", MEM_REQ, 0);
    I_REQ = 1'b0;
    @(negedge CLK);
    chk("trailing_no_memreq2", MEM_REQ, 0);

    // store with one extra memory wait cycle
    fixed_lat = 1; wait_cnt = 1;
    d_pay.push_back({1'b1, 4'b0011, 32'h8000_2004, 32'hDEAD_BEEF});
    d_exp.push_back(d_last);
    issued++;
    D_WE = 1'b1; D_BE = 4'b0011; D_ADDR = 32'h8000_2004; D_WDATA = 32'hDEAD_BEEF; D_REQ = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); cyc++;
      if (D_ACK !== 1'b1) chk("stall_mem_wait", STALL_MEM, 1);
    end while (D_ACK !== 1'b1 && cyc < 20);
    chk("store_latency", cyc, 3);
    D_REQ = 1'b0;
    @(negedge CLK);
    chk("d_ack_single_pulse", D_ACK, 0);

    // randomized mixed traffic
    fixed_lat = -1;
    fork
      drive_i(30, 1'b1);
      drive_d(30, 1'b1);
    join
    repeat (5) @(negedge CLK);

    // reset during a data access, then a stray MEM_ACK while idle
    mem_en = 1'b0;
    D_WE = 1'b0; D_ADDR = 32'h8000_0040; D_REQ = 1'b1;
    w = 0;
    do begin @(negedge CLK); w++; end while (MEM_REQ !== 1'b1 && w < 10);
    chk("mid_busy_memreq", MEM_REQ, 1);
    RSTN = 1'b0;
    @(negedge CLK);
    chk("mid_rst_memreq", MEM_REQ, 0);
    chk("mid_rst_dack", D_ACK, 0);
    chk("mid_rst_drdata", D_RDATA, 0);
    RSTN = 1'b1; D_REQ = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    chk("late_ack_memreq", MEM_REQ, 0);
    chk("late_ack_dack", D_ACK, 0);
    @(negedge CLK);
    chk("late_ack_dack2", D_ACK, 0);
    MEM_ACK = 1'b0;
    d_last = 32'h0;
    wait_cnt = 0;
    mem_en = 1'b1;
    @(negedge CLK);

    // contention with both requesters held continuously; derive grant order from the rules
    i_left = 5; d_left = 7; prev = -1; starve = 0;
    while (i_left > 0 || d_left > 0) begin
      bit i_ok, d_ok;
      i_ok = (i_left > 0) && (prev != 0);
      d_ok = (d_left > 0) && (prev != 1);
      if (!i_ok && !d_ok) prev = -1;
      else if (d_ok && (!i_ok || starve != LIMIT)) begin
        exp_order.push_back(1);
        if (i_left > 0 && starve < LIMIT) starve++;
        d_left--; prev = 1;
      end else begin
        exp_order.push_back(0);
        starve = 0; i_left--; prev = 0;
      end
    end
    grant_q.delete();
    fork
      drive_i(5, 1'b0);
      drive_d(7, 1'b0);
    join
    repeat (4) @(negedge CLK);
    chk("grant_count", grant_q.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < grant_q.size(); k++)
      chk($sformatf("grant_order_%0d", k), grant_q[k], exp_order[k]);

`ifdef ARB_TIMEOUT_EN
    mem_en = 1'b0;
    I_ADDR = 32'h300; I_REQ = 1'b1;
    i_exp.push_back(32'h0);
    w = 0; busy = 0;
    do begin
      @(negedge CLK); w++;
      if (MEM_REQ === 1'b1) busy++;
    end while (I_ACK !== 1'b1 && w < 60);
    chk("timeout_busy_cycles", busy, 15);
    chk("err_set", ERR, 1);
    I_REQ = 1'b0;
    wait_cnt = 0;
    mem_en = 1'b1;
    @(negedge CLK);
    drive_d(2, 1'b1);
    chk("err_sticky", ERR, 1);
`else
    busy = 0;
    chk("err_tied_low", ERR, busy);
`endif

    repeat (4) @(negedge CLK);
    chk("handshakes", hshk, issued);
    chk("queues_drained", i_exp.size() + d_exp.size() + i_pay.size() + d_pay.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
